// File: rtl/cpu_pkg.sv
// cpu_pkg: phase encodings, ARM condition codes and instruction classes shared by the control path
package cpu_pkg;
  typedef enum logic [1:0] {FETCH = 2'b00, READ = 2'b01, EXEC = 2'b10, WB = 2'b11} phase_e;
  typedef enum logic [1:0] {CLS_DP = 2'b00, CLS_MEM = 2'b01, CLS_BR = 2'b10, CLS_ILL = 2'b11} class_e;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
endpackage

// File: rtl/cpu_control_if.sv
// cpu_control_if: instruction-fetch and data-memory handshakes between the control unit and memories
interface cpu_control_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  modport master (output imem_req, mem_req, mem_we, input imem_ack, instr_in, mem_ack);
  modport slave (input imem_req, mem_req, mem_we, output imem_ack, instr_in, mem_ack);
endinterface

// File: rtl/cpu_control_cond_check.sv
// cond_check: evaluates an ARM condition field against latched NZCV flags
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  // map each condition code to its flag predicate; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: four-phase fetch/read/exec/writeback sequencer and instruction decoder
module cpu_control
  import cpu_pkg::*;
#(
  parameter int REG_SIZE  = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  cpu_control_if.master               bus,
  input  logic [3:0]                  alu_flags,
  output logic [3:0]                  flags,
  output logic [1:0]                  phase,
  output logic [ADDR_SIZE-1:0]        select1,
  output logic [ADDR_SIZE-1:0]        select2,
  output logic [ADDR_SIZE-1:0]        wselect,
  output logic [ADDR_SIZE-1:0]        shft_reg,
  output logic signed [REG_SIZE-1:0]  offset,
  output logic                        we,
  output logic                        from_mem,
  output logic                        link_sel,
  output logic                        illegal_instr
);
  phase_e      phase_q, phase_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  flags_q, flags_d;
  logic        pass, is_dp, is_mem, is_br, is_ill, is_ldr, is_str, is_bl, mem_go;
  logic        unused_bits;
  cond_check u_cond (.cond(instr_q[31:28]), .flags(flags_q), .pass(pass));
  assign is_dp       = instr_q[27:26] == CLS_DP;
  assign is_mem      = instr_q[27:26] == CLS_MEM;
  assign is_br       = instr_q[27:26] == CLS_BR;
  assign is_ill      = instr_q[27:26] == CLS_ILL;
  assign is_ldr      = is_mem && instr_q[20];
  assign is_str      = is_mem && !instr_q[20];
  assign is_bl       = is_br && instr_q[24];
  assign mem_go      = phase_q == EXEC && is_mem && pass;
  assign unused_bits = ^instr_q[7:5];
  // phase sequencing; EXEC waits on the data handshake only for a live load/store
  always_comb begin
    phase_d = FETCH;
    case (phase_q)
      FETCH:   phase_d = bus.imem_ack ? READ : FETCH;
      READ:    phase_d = EXEC;
      EXEC:    phase_d = (mem_go && !bus.mem_ack) ? EXEC : WB;
      default: phase_d = FETCH;
    endcase
    instr_d = (phase_q == FETCH && bus.imem_ack) ? bus.instr_in : instr_q;
    flags_d = (phase_q == WB && is_dp && instr_q[20] && pass) ? alu_flags : flags_q;
  end
  // state registers; reset abandons any handshake in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= FETCH;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      phase_q <= phase_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end
  assign phase         = phase_q;
  assign flags         = flags_q;
  assign bus.imem_req  = phase_q == FETCH && !reset;
  assign bus.mem_req   = mem_go;
  assign bus.mem_we    = mem_go && is_str;
  assign select1       = ADDR_SIZE'(instr_q[19:16]);
  assign select2       = ADDR_SIZE'(is_str ? instr_q[15:12] : instr_q[3:0]);
  assign wselect       = is_bl ? ADDR_SIZE'(14) : ADDR_SIZE'(instr_q[15:12]);
  assign shft_reg      = (is_dp && !instr_q[25] && instr_q[4]) ? ADDR_SIZE'(instr_q[11:8]) : '0;
  assign offset        = (is_br && pass) ? (REG_SIZE'($signed(instr_q[23:0])) << 2) + REG_SIZE'(4) : '0;
  assign we            = phase_q == WB && pass && ((is_dp && instr_q[24:23] != 2'b10) || is_ldr || is_bl);
  assign from_mem      = is_ldr;
  assign link_sel      = is_bl;
  assign illegal_instr = phase_q == WB && is_ill;
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed vectors through fetch stalls, load wait, branches, flags and mid-store reset
module tb_cpu_control;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         alu_flags, flags;
  logic [1:0]         phase;
  logic [4:0]         select1, select2, wselect, shft_reg;
  logic signed [31:0] offset;
  logic               we, from_mem, link_sel, illegal_instr;
  int                 n_vec = 0;
  int                 n_err = 0;
  cpu_control_if bus ();
  cpu_control #(.REG_SIZE(32), .ADDR_SIZE(5)) dut (
    .clk(clk), .reset(reset), .bus(bus), .alu_flags(alu_flags), .flags(flags),
    .phase(phase), .select1(select1), .select2(select2), .wselect(wselect),
    .shft_reg(shft_reg), .offset(offset), .we(we), .from_mem(from_mem),
    .link_sel(link_sel), .illegal_instr(illegal_instr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fetch(input logic [31:0] instr);
    bus.imem_ack = 1'b1;
    bus.instr_in = instr;
    tick();
    bus.imem_ack = 1'b0;
  endtask
  initial begin
    bus.imem_ack = 1'b0;
    bus.instr_in = '0;
    bus.mem_ack  = 1'b0;
    alu_flags    = 4'b0000;
    @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_flags", flags, 0);
    chk("rst_we", we, 0);
    chk("rst_offset", offset, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    reset = 1'b0;
    #1;
    chk("rel_imem_req", bus.imem_req, 1);
    chk("rel_phase", phase, 0);
    fetch(32'hE0812003);
    chk("add_read", phase, 1);
    tick();
    chk("add_exec", phase, 2);
    chk("add_mem_req", bus.mem_req, 0);
    tick();
    chk("add_wb", phase, 3);
    chk("add_select1", select1, 1);
    chk("add_select2", select2, 3);
    chk("add_wselect", wselect, 2);
    chk("add_we", we, 1);
    chk("add_offset", offset, 0);
    chk("add_shft", shft_reg, 0);
    tick();
    chk("add_back_fetch", phase, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_phase", phase, 0);
      chk("stall_imem_req", bus.imem_req, 1);
      tick();
    end
    chk("stall_phase4", phase, 0);
    chk("stall_imem_req4", bus.imem_req, 1);
    fetch(32'hE5912000);
    chk("ldr_read", phase, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("ldr_exec_wait", phase, 2);
      chk("ldr_mem_req", bus.mem_req, 1);
      chk("ldr_mem_we", bus.mem_we, 0);
      chk("ldr_we_exec", we, 0);
      tick();
    end
    chk("ldr_exec3", phase, 2);
    chk("ldr_mem_req3", bus.mem_req, 1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ldr_wb", phase, 3);
    chk("ldr_from_mem", from_mem, 1);
    chk("ldr_we", we, 1);
    chk("ldr_wselect", wselect, 2);
    chk("ldr_mem_req_wb", bus.mem_req, 0);
    tick();
    fetch(32'hEAFFFFFE);
    chk("b_offset_read", offset, 32'hFFFFFFFC);
    tick();
    tick();
    chk("b_wb", phase, 3);
    chk("b_we", we, 0);
    chk("b_offset_wb", offset, 32'hFFFFFFFC);
    chk("b_link_sel", link_sel, 0);
    tick();
    fetch(32'hEBFFFFFE);
    tick();
    tick();
    chk("bl_wselect", wselect, 14);
    chk("bl_link_sel", link_sel, 1);
    chk("bl_we", we, 1);
    chk("bl_offset", offset, 32'hFFFFFFFC);
    tick();
    fetch(32'hE0812312);
    chk("shf_shft_reg", shft_reg, 3);
    chk("shf_select2", select2, 2);
    tick();
    tick();
    tick();
    fetch(32'hEC000000);
    tick();
    chk("ill_mem_req", bus.mem_req, 0);
    chk("ill_exec_flag", illegal_instr, 0);
    tick();
    chk("ill_flag", illegal_instr, 1);
    chk("ill_we", we, 0);
    tick();
    chk("ill_flag_drop", illegal_instr, 0);
    alu_flags = 4'b0100;
    fetch(32'hE1500000);
    tick();
    tick();
    chk("cmp_wb", phase, 3);
    chk("cmp_we", we, 0);
    chk("cmp_flags_pre", flags, 0);
    tick();
    chk("cmp_flags", flags, 4'b0100);
    alu_flags = 4'b0000;
    fetch(32'h1AFFFFFE);
    chk("bne_offset_read", offset, 0);
    tick();
    chk("bne_mem_req", bus.mem_req, 0);
    tick();
    chk("bne_we", we, 0);
    chk("bne_offset_wb", offset, 0);
    chk("bne_flags_kept", flags, 4'b0100);
    tick();
    fetch(32'hE5812000);
    tick();
    chk("str_exec", phase, 2);
    chk("str_mem_req", bus.mem_req, 1);
    chk("str_mem_we", bus.mem_we, 1);
    chk("str_select2", select2, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("str_rst_phase", phase, 0);
    chk("str_rst_mem_req", bus.mem_req, 0);
    chk("str_rst_mem_we", bus.mem_we, 0);
    chk("str_rst_imem_req", bus.imem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_phase", phase, 0);
    chk("post_rst_imem_req", bus.imem_req, 1);
    chk("post_rst_flags", flags, 0);
    chk("post_rst_select2", select2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
